// File: rtl/wb_master_bridge.sv
// Single-outstanding load/store to pipelined Wishbone B4 master bridge.
// One transfer at a time, with a cycle timeout once the strobe has been accepted.
module wb_master_bridge #(
   parameter int TIMEOUT_CYC = 16,
   parameter int ADDR_W      = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   input  logic [1:0]        i_size,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [31:0]       o_rdata,
   output logic              o_cyc,
   output logic              o_stb,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_we,
   output logic [31:0]       o_data,
   output logic [3:0]        o_sel,
   input  logic              i_ack,
   input  logic              i_err,
   input  logic [31:0]       i_data,
   input  logic              i_stall
);

   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int LAST  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             bus_done;
   logic             timeout_hit;

   function automatic logic [3:0] size_sel(input logic [1:0] size);
      case (size)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] sel_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

   // Slave response ends the cycle either in WAIT or in the same cycle the strobe is accepted.
   always_comb begin
      bus_done    = 1'b0;
      timeout_hit = 1'b0;
      if (((state == S_STROBE) && !i_stall) || (state == S_WAIT))
         bus_done = i_ack || i_err;
      if ((TIMEOUT_CYC != 0) && (state == S_WAIT) && !(i_ack || i_err) && (cnt >= CNT_LAST))
         timeout_hit = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_err   <= 1'b0;
         o_rdata <= '0;
         o_cyc   <= 1'b0;
         o_stb   <= 1'b0;
         o_addr  <= '0;
         o_we    <= 1'b0;
         o_data  <= '0;
         o_sel   <= '0;
      end else begin
         o_done <= 1'b0;
         o_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_req) begin
                  if (i_size == 2'b11) begin
                     o_done <= 1'b1;
                     o_err  <= 1'b1;
                  end else begin
                     o_addr <= i_addr;
                     o_we   <= i_we;
                     o_sel  <= size_sel(i_size);
                     o_data <= i_wdata & sel_mask(size_sel(i_size));
                     o_cyc  <= 1'b1;
                     o_stb  <= 1'b1;
                     o_busy <= 1'b1;
                     state  <= S_STROBE;
                  end
               end
            end
            S_STROBE: begin
               if (!i_stall) begin
                  o_stb <= 1'b0;
                  cnt   <= CNT_W'(1);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if ((TIMEOUT_CYC != 0) && (cnt < CNT_LAST))
                  cnt <= cnt + CNT_W'(1);
            end
            default: state <= S_IDLE;
         endcase

         // Completion overrides the per-state updates above; error beats ack.
         if (bus_done || timeout_hit) begin
            o_cyc  <= 1'b0;
            o_stb  <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_err  <= i_err || timeout_hit;
            if (!i_err && !timeout_hit && !o_we)
               o_rdata <= i_data & sel_mask(o_sel);
            state  <= S_IDLE;
         end
      end
   end

endmodule
